// File: rtl/regfile_banked_pkg.sv
// Shared types and helpers for the banked register file.
// Bank encoding, default sizes and pair-index arithmetic.
package regfile_pkg;

    typedef enum logic {
        BANK_INT = 1'b0,
        BANK_FP  = 1'b1
    } bank_e;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;

    function automatic int pair_idx(int addr, int numRegs);
        return (addr + 1) % numRegs;
    endfunction

    function automatic logic pair_wraps(int addr, int numRegs);
        return addr == numRegs - 1;
    endfunction

endpackage

// File: rtl/regfile_banked_if.sv
// Read, write and reserve bundle of the banked register file.
// master drives requests, slave is the register file.
interface regfile_banked_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 3
);
    logic [NUM_RD-1:0]        rd_bank;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD*DATA_W-1:0] rd_data_hi;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic                     wr_bank;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_pair;
    logic [DATA_W-1:0]        wr_data_hi;
    logic                     wr_release;
    logic                     rsv_en;
    logic                     rsv_bank;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     rsv_pair;
    logic                     pair_err;

    modport master (
        output rd_bank, rd_addr,
        output wr_en, wr_bank, wr_addr, wr_data,
        output wr_pair, wr_data_hi, wr_release,
        output rsv_en, rsv_bank, rsv_addr, rsv_pair,
        input  rd_data, rd_data_hi, rd_busy, pair_err
    );

    modport slave (
        input  rd_bank, rd_addr,
        input  wr_en, wr_bank, wr_addr, wr_data,
        input  wr_pair, wr_data_hi, wr_release,
        input  rsv_en, rsv_bank, rsv_addr, rsv_pair,
        output rd_data, rd_data_hi, rd_busy, pair_err
    );
endinterface

// File: rtl/regfile_banked_rdport.sv
// One registered read port: bank mux, write-first bypass, output flops.
// Integer r0 is never stored nor written, so it always reads zero.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bank,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] intRegs [NUM_REGS],
    input  logic [DATA_W-1:0] fpRegs  [NUM_REGS],
    input  logic [NUM_REGS-1:0] intBusyNext,
    input  logic [NUM_REGS-1:0] fpBusyNext,
    input  logic              loWe,
    input  logic              wrBank,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              hiWe,
    input  logic [ADDR_W-1:0] hiAddr,
    input  logic [DATA_W-1:0] wrDataHi,
    output logic [DATA_W-1:0] rdData,
    output logic [DATA_W-1:0] rdDataHi,
    output logic              rdBusy
);
    logic [ADDR_W-1:0] hiIdx;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;
    logic              busy;

    always_comb begin
        hiIdx = ADDR_W'(pair_idx(int'(addr), NUM_REGS));
        if (bank == BANK_FP) begin
            lo   = fpRegs[addr];
            hi   = fpRegs[hiIdx];
            busy = fpBusyNext[addr];
        end else begin
            lo   = intRegs[addr];
            hi   = intRegs[hiIdx];
            busy = intBusyNext[addr];
        end
        // hiWe is only ever raised for the FP bank
        if (loWe && wrBank == bank && wrAddr == addr)
            lo = wrData;
        if (loWe && wrBank == bank && wrAddr == hiIdx)
            hi = wrData;
        if (hiWe && bank == BANK_FP && hiAddr == addr)
            lo = wrDataHi;
        if (hiWe && bank == BANK_FP && hiAddr == hiIdx)
            hi = wrDataHi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdData   <= '0;
            rdDataHi <= '0;
            rdBusy   <= 1'b0;
        end else begin
            rdData   <= lo;
            rdDataHi <= hi;
            rdBusy   <= busy;
        end
    end
endmodule

// File: rtl/regfile_banked.sv
// Dual-bank (INT/FP) register file with registered reads, pair writes,
// write-first bypass and a per-register busy scoreboard.
module regfile_banked
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 3
) (
    input  logic clk,
    input  logic rst_n,
    regfile_banked_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   intRegs [NUM_REGS];
    logic [DATA_W-1:0]   fpRegs  [NUM_REGS];
    logic [NUM_REGS-1:0] intBusy;
    logic [NUM_REGS-1:0] fpBusy;
    logic [NUM_REGS-1:0] intBusyNext;
    logic [NUM_REGS-1:0] fpBusyNext;
    logic [ADDR_W-1:0]   hiAddr;
    logic [ADDR_W-1:0]   rsvHiAddr;
    logic                wrPairOk;
    logic                rsvPairOk;
    logic                loWe;
    logic                hiWe;
    logic                pairErr;
    logic                pairErrNext;

    logic [NUM_RD-1:0][DATA_W-1:0] rdData;
    logic [NUM_RD-1:0][DATA_W-1:0] rdDataHi;
    logic [NUM_RD-1:0]             rdBusy;

    always_comb begin
        hiAddr    = ADDR_W'(pair_idx(int'(bus.wr_addr), NUM_REGS));
        rsvHiAddr = ADDR_W'(pair_idx(int'(bus.rsv_addr), NUM_REGS));
        wrPairOk  = bus.wr_pair && bus.wr_bank == BANK_FP
                    && !pair_wraps(int'(bus.wr_addr), NUM_REGS);
        rsvPairOk = bus.rsv_pair && bus.rsv_bank == BANK_FP
                    && !pair_wraps(int'(bus.rsv_addr), NUM_REGS);
        loWe = bus.wr_en
               && !(bus.wr_bank == BANK_INT && bus.wr_addr == '0);
        hiWe = bus.wr_en && wrPairOk;
        pairErrNext = (bus.wr_en && bus.wr_pair && !wrPairOk)
                      || (bus.rsv_en && bus.rsv_pair && !rsvPairOk);

        intBusyNext = intBusy;
        fpBusyNext  = fpBusy;
        if (bus.wr_en && bus.wr_release) begin
            if (bus.wr_bank == BANK_FP)
                fpBusyNext[bus.wr_addr] = 1'b0;
            else
                intBusyNext[bus.wr_addr] = 1'b0;
            if (hiWe)
                fpBusyNext[hiAddr] = 1'b0;
        end
        // reserve is applied after release so it wins on a collision
        if (bus.rsv_en) begin
            if (bus.rsv_bank == BANK_FP) begin
                fpBusyNext[bus.rsv_addr] = 1'b1;
                if (rsvPairOk)
                    fpBusyNext[rsvHiAddr] = 1'b1;
            end else begin
                intBusyNext[bus.rsv_addr] = 1'b1;
            end
        end
        intBusyNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                intRegs[i] <= '0;
                fpRegs[i]  <= '0;
            end
            intBusy <= '0;
            fpBusy  <= '0;
            pairErr <= 1'b0;
        end else begin
            if (loWe) begin
                if (bus.wr_bank == BANK_FP)
                    fpRegs[bus.wr_addr] <= bus.wr_data;
                else
                    intRegs[bus.wr_addr] <= bus.wr_data;
            end
            if (hiWe)
                fpRegs[hiAddr] <= bus.wr_data_hi;
            intBusy <= intBusyNext;
            fpBusy  <= fpBusyNext;
            pairErr <= pairErrNext;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRd
        regfile_rdport #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W)
        ) uPort (
            .clk         (clk),
            .rst_n       (rst_n),
            .bank        (bus.rd_bank[k]),
            .addr        (bus.rd_addr[k*ADDR_W +: ADDR_W]),
            .intRegs     (intRegs),
            .fpRegs      (fpRegs),
            .intBusyNext (intBusyNext),
            .fpBusyNext  (fpBusyNext),
            .loWe        (loWe),
            .wrBank      (bus.wr_bank),
            .wrAddr      (bus.wr_addr),
            .wrData      (bus.wr_data),
            .hiWe        (hiWe),
            .hiAddr      (hiAddr),
            .wrDataHi    (bus.wr_data_hi),
            .rdData      (rdData[k]),
            .rdDataHi    (rdDataHi[k]),
            .rdBusy      (rdBusy[k])
        );
    end

    assign bus.rd_data    = rdData;
    assign bus.rd_data_hi = rdDataHi;
    assign bus.rd_busy    = rdBusy;
    assign bus.pair_err   = pairErr;
endmodule
